// File: rtl/int_exec_pipe.sv
// Integer execute pipe (RV32I/RV64I reg-reg/reg-imm ops), STAGES cycles latency, 1 op/cycle; INT_EXEC_ZICOND_EN adds czero.eqz/nez.
// Valid/ready backpressure with bubble collapse; output held while o_valid && !i_ready; i_flush kills all in-flight ops.
module int_exec_pipe #(
  parameter int XLEN    = 32,
  parameter int STAGES  = 1,
  parameter int WADDR_W = 5,
`ifdef INT_EXEC_ZICOND_EN
  localparam int OP_W   = 12
`else
  localparam int OP_W   = 10
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [OP_W-1:0]    i_op,
  input  logic [XLEN-1:0]    i_src1,
  input  logic [XLEN-1:0]    i_src2,
  input  logic [WADDR_W-1:0] i_waddr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_res,
  output logic [WADDR_W-1:0] o_waddr,
  output logic               o_we,
  output logic               o_illegal,
  output logic               o_busy
);

  localparam int SH_W = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]    res;
    logic [WADDR_W-1:0] waddr;
    logic               ill;
  } stage_t;

  stage_t            st_q [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ld;
  logic              op_onehot;
  logic [SH_W-1:0]   shamt;
  logic [XLEN-1:0]   alu_res;
  logic              in_xfer;

  assign shamt     = i_src2[SH_W-1:0];
  assign op_onehot = (i_op != '0) && ((i_op & (i_op - OP_W'(1))) == '0);

  always_comb begin
    alu_res = '0;
    if (op_onehot) begin
      case (1'b1)
        i_op[0]: alu_res = i_src1 + i_src2;
        i_op[1]: alu_res = i_src1 - i_src2;
        i_op[2]: alu_res = {{(XLEN-1){1'b0}}, ($signed(i_src1) < $signed(i_src2))};
        i_op[3]: alu_res = {{(XLEN-1){1'b0}}, (i_src1 < i_src2)};
        i_op[4]: alu_res = i_src1 ^ i_src2;
        i_op[5]: alu_res = i_src1 | i_src2;
        i_op[6]: alu_res = i_src1 & i_src2;
        i_op[7]: alu_res = i_src1 << shamt;
        i_op[8]: alu_res = i_src1 >> shamt;
        i_op[9]: alu_res = $unsigned($signed(i_src1) >>> shamt);
`ifdef INT_EXEC_ZICOND_EN
        i_op[10]: alu_res = (i_src2 == '0) ? '0 : i_src1;
        i_op[11]: alu_res = (i_src2 != '0) ? '0 : i_src1;
`endif
        default: alu_res = '0;
      endcase
    end
  end

  // A stage may load if it, or any later stage, is empty, or the output is being taken.
  always_comb begin : ready_chain
    logic acc;
    acc = i_ready;
    ld  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc   = acc | ~v_q[k];
      ld[k] = acc;
    end
  end

  assign o_ready = ld[0];
  assign in_xfer = i_valid && ld[0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else begin
      if (ld[0]) begin
        v_q[0] <= in_xfer;
        if (in_xfer) st_q[0] <= '{res: alu_res, waddr: i_waddr, ill: !op_onehot};
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) st_q[k] <= st_q[k-1];
        end
      end
      if (i_flush) v_q <= '0;
    end
  end

  assign o_valid   = v_q[STAGES-1];
  assign o_res     = st_q[STAGES-1].res;
  assign o_waddr   = st_q[STAGES-1].waddr;
  assign o_illegal = v_q[STAGES-1] && st_q[STAGES-1].ill;
  assign o_we      = v_q[STAGES-1] && (st_q[STAGES-1].waddr != '0);
  assign o_busy    = |v_q;

endmodule

// File: tb/tb_int_exec_pipe.sv
// Directed bench for int_exec_pipe: three instances (STAGES = 1, 2, 3) share the input side.
module tb_int_exec_pipe;

`ifdef INT_EXEC_ZICOND_EN
  localparam int OP_W = 12;
`else
  localparam int OP_W = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn, i_flush, i_valid, i_ready;
  logic [OP_W-1:0] i_op;
  logic [31:0]     i_src1, i_src2;
  logic [4:0]      i_waddr;

  logic        o_ready_s1, o_valid_s1, o_we_s1, o_illegal_s1, o_busy_s1;
  logic [31:0] o_res_s1;
  logic [4:0]  o_waddr_s1;
  logic        o_ready_s2, o_valid_s2, o_we_s2, o_illegal_s2, o_busy_s2;
  logic [31:0] o_res_s2;
  logic [4:0]  o_waddr_s2;
  logic        o_ready_s3, o_valid_s3, o_we_s3, o_illegal_s3, o_busy_s3;
  logic [31:0] o_res_s3;
  logic [4:0]  o_waddr_s3;

  int checks = 0;
  int errors = 0;

  int_exec_pipe #(.XLEN(32), .STAGES(1), .WADDR_W(5)) u1 (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_s1),
    .i_op(i_op), .i_src1(i_src1), .i_src2(i_src2), .i_waddr(i_waddr),
    .o_valid(o_valid_s1), .i_ready(i_ready), .o_res(o_res_s1), .o_waddr(o_waddr_s1),
    .o_we(o_we_s1), .o_illegal(o_illegal_s1), .o_busy(o_busy_s1));

  int_exec_pipe #(.XLEN(32), .STAGES(2), .WADDR_W(5)) u2 (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_s2),
    .i_op(i_op), .i_src1(i_src1), .i_src2(i_src2), .i_waddr(i_waddr),
    .o_valid(o_valid_s2), .i_ready(i_ready), .o_res(o_res_s2), .o_waddr(o_waddr_s2),
    .o_we(o_we_s2), .o_illegal(o_illegal_s2), .o_busy(o_busy_s2));

  int_exec_pipe #(.XLEN(32), .STAGES(3), .WADDR_W(5)) u3 (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_s3),
    .i_op(i_op), .i_src1(i_src1), .i_src2(i_src2), .i_waddr(i_waddr),
    .o_valid(o_valid_s3), .i_ready(i_ready), .o_res(o_res_s3), .o_waddr(o_waddr_s3),
    .o_we(o_we_s3), .o_illegal(o_illegal_s3), .o_busy(o_busy_s3));

  // op index, src1, src2, hand-computed result
  int          t_op  [13] = '{0, 1, 9, 2, 3, 4, 5, 6, 7, 8, 9, 3, 2};
  logic [31:0] t_a   [13] = '{32'h7FFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h3, 32'h80000000,
                              32'h7FFFFFFF, 32'h1, 32'h1};
  logic [31:0] t_b   [13] = '{32'h1, 32'h1, 32'h24, 32'h1, 32'h1, 32'hFF00FF00, 32'h0F0F0000,
                              32'hFF00FF00, 32'h21, 32'h3F, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_exp [13] = '{32'h80000000, 32'hFFFFFFFF, 32'hF8000000, 32'h1, 32'h0,
                              32'h0FF00FF0, 32'hFFFFF0F0, 32'hF000F000, 32'h6, 32'h1,
                              32'h07FFFFFF, 32'h1, 32'h0};

  function automatic logic [OP_W-1:0] opb(input int idx);
    return OP_W'(1) << idx;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op_idx, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    i_valid = 1'b1;
    i_op    = opb(op_idx);
    i_src1  = a;
    i_src2  = b;
    i_waddr = wa;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_op = '0; i_src1 = '0; i_src2 = '0; i_waddr = '0;
    cyc(); cyc();
    checks++;
    if ({o_valid_s1, o_we_s1, o_illegal_s1, o_busy_s1, o_ready_s1, o_res_s1, o_waddr_s1} !== {5'b00001, 37'h0}) begin
      errors++; $display("FAIL reset_s1: got v/we/ill/busy/rdy=%b res=%h wa=%h expected 00001 0 0",
        {o_valid_s1, o_we_s1, o_illegal_s1, o_busy_s1, o_ready_s1}, o_res_s1, o_waddr_s1);
    end
    checks++;
    if ({o_valid_s2, o_we_s2, o_illegal_s2, o_busy_s2, o_ready_s2, o_res_s2, o_waddr_s2} !== {5'b00001, 37'h0}) begin
      errors++; $display("FAIL reset_s2: got v/we/ill/busy/rdy=%b res=%h wa=%h expected 00001 0 0",
        {o_valid_s2, o_we_s2, o_illegal_s2, o_busy_s2, o_ready_s2}, o_res_s2, o_waddr_s2);
    end
    checks++;
    if ({o_valid_s3, o_we_s3, o_illegal_s3, o_busy_s3, o_ready_s3, o_res_s3, o_waddr_s3} !== {5'b00001, 37'h0}) begin
      errors++; $display("FAIL reset_s3: got v/we/ill/busy/rdy=%b res=%h wa=%h expected 00001 0 0",
        {o_valid_s3, o_we_s3, o_illegal_s3, o_busy_s3, o_ready_s3}, o_res_s3, o_waddr_s3);
    end
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_alu();
    i_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(t_op[i], t_a[i], t_b[i], 5'(i + 1));
      cyc();
      checks++;
      if (o_res_s1 !== t_exp[i]) begin
        errors++; $display("FAIL alu_res[%0d]: got %h expected %h", i, o_res_s1, t_exp[i]);
      end
      checks++;
      if ({o_valid_s1, o_we_s1, o_illegal_s1, o_waddr_s1} !== {3'b110, 5'(i + 1)}) begin
        errors++; $display("FAIL alu_ctl[%0d]: got v/we/ill=%b wa=%0d expected 110 wa=%0d",
          i, {o_valid_s1, o_we_s1, o_illegal_s1}, o_waddr_s1, i + 1);
      end
    end
    idle(4);
    checks++;
    if ({o_valid_s1, o_busy_s1, o_busy_s3} !== 3'b000) begin
      errors++; $display("FAIL alu_drain: got v1/busy1/busy3=%b expected 000", {o_valid_s1, o_busy_s1, o_busy_s3});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_res;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'((i + 1) * 256), 32'h1, 5'(i + 1));
      #1;
      checks++;
      if (o_ready_s3 !== 1'b1) begin
        errors++; $display("FAIL bp_fill_ready[%0d]: got %b expected 1", i, o_ready_s3);
      end
      cyc();
    end
    drive(0, 32'h400, 32'h1, 5'd4);
    #1;
    checks++;
    if ({o_valid_s3, o_ready_s3, o_res_s3} !== {2'b10, 32'h101}) begin
      errors++; $display("FAIL bp_full: got v/rdy=%b res=%h expected 10 00000101", {o_valid_s3, o_ready_s3}, o_res_s3);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({o_valid_s3, o_ready_s3, o_res_s3, o_waddr_s3} !== {2'b10, 32'h101, 5'd1}) begin
        errors++; $display("FAIL bp_hold[%0d]: got v/rdy=%b res=%h wa=%0d expected 10 00000101 1",
          i, {o_valid_s3, o_ready_s3}, o_res_s3, o_waddr_s3);
      end
    end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready_s3 !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 1", o_ready_s3);
    end
    cyc();
    i_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      exp_res = 32'(i * 256 + 1);
      checks++;
      if ({o_valid_s3, o_res_s3, o_waddr_s3} !== {1'b1, exp_res, 5'(i)}) begin
        errors++; $display("FAIL bp_drain[%0d]: got v=%b res=%h wa=%0d expected 1 %h %0d",
          i, o_valid_s3, o_res_s3, o_waddr_s3, exp_res, i);
      end
      cyc();
    end
    checks++;
    if ({o_valid_s3, o_busy_s3} !== 2'b00) begin
      errors++; $display("FAIL bp_nodup: got v/busy=%b expected 00", {o_valid_s3, o_busy_s3});
    end
    idle(4);
  endtask

  task automatic test_flush();
    i_ready = 1'b1;
    drive(2, 32'hFFFFFFFF, 32'h1, 5'd5);
    cyc();
    drive(3, 32'hFFFFFFFF, 32'h1, 5'd6);
    cyc();
    checks++;
    if ({o_valid_s2, o_res_s2, o_waddr_s2} !== {1'b1, 32'h1, 5'd5}) begin
      errors++; $display("FAIL flush_pre: got v=%b res=%h wa=%0d expected 1 00000001 5", o_valid_s2, o_res_s2, o_waddr_s2);
    end
    drive(0, 32'h7, 32'h7, 5'd7);
    i_flush = 1'b1;
    #1;
    checks++;
    if ({o_ready_s2, o_busy_s2} !== 2'b11) begin
      errors++; $display("FAIL flush_ready: got rdy/busy=%b expected 11", {o_ready_s2, o_busy_s2});
    end
    cyc();
    i_flush = 1'b0;
    i_valid = 1'b0;
    checks++;
    if (o_busy_s2 !== 1'b0) begin
      errors++; $display("FAIL flush_busy: got %b expected 0", o_busy_s2);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid_s2 !== 1'b0) begin
        errors++; $display("FAIL flush_valid[%0d]: got %b expected 0", i, o_valid_s2);
      end
      cyc();
    end
    idle(2);
  endtask

  task automatic test_illegal();
    i_ready = 1'b1;
    i_valid = 1'b1; i_op = OP_W'(3); i_src1 = 32'h5; i_src2 = 32'h6; i_waddr = 5'd0;
    cyc();
    checks++;
    if ({o_valid_s1, o_illegal_s1, o_we_s1, o_res_s1} !== {3'b110, 32'h0}) begin
      errors++; $display("FAIL illegal_two_hot: got v/ill/we=%b res=%h expected 110 0",
        {o_valid_s1, o_illegal_s1, o_we_s1}, o_res_s1);
    end
    i_op = '0; i_waddr = 5'd9;
    cyc();
    checks++;
    if ({o_valid_s1, o_illegal_s1, o_we_s1, o_res_s1, o_waddr_s1} !== {3'b111, 32'h0, 5'd9}) begin
      errors++; $display("FAIL illegal_zero: got v/ill/we=%b res=%h wa=%0d expected 111 0 9",
        {o_valid_s1, o_illegal_s1, o_we_s1}, o_res_s1, o_waddr_s1);
    end
    drive(0, 32'h5, 32'h6, 5'd0);
    cyc();
    checks++;
    if ({o_valid_s1, o_illegal_s1, o_we_s1, o_res_s1} !== {3'b100, 32'hB}) begin
      errors++; $display("FAIL illegal_clear: got v/ill/we=%b res=%h expected 100 0000000b",
        {o_valid_s1, o_illegal_s1, o_we_s1}, o_res_s1);
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    drive(0, 32'h1, 32'h2, 5'd3);
    cyc();
    drive(0, 32'h4, 32'h5, 5'd6);
    cyc();
    checks++;
    if ({o_valid_s2, o_busy_s2, o_res_s2} !== {2'b11, 32'h3}) begin
      errors++; $display("FAIL rstmid_pre: got v/busy=%b res=%h expected 11 00000003", {o_valid_s2, o_busy_s2}, o_res_s2);
    end
    rstn = 1'b0;
    i_valid = 1'b0;
    cyc();
    checks++;
    if ({o_valid_s2, o_we_s2, o_illegal_s2, o_busy_s2, o_res_s2, o_waddr_s2} !== 41'h0) begin
      errors++; $display("FAIL rstmid_out: got v/we/ill/busy=%b res=%h wa=%0d expected 0000 0 0",
        {o_valid_s2, o_we_s2, o_illegal_s2, o_busy_s2}, o_res_s2, o_waddr_s2);
    end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({o_valid_s2, o_busy_s2} !== 2'b00) begin
        errors++; $display("FAIL rstmid_after[%0d]: got v/busy=%b expected 00", i, {o_valid_s2, o_busy_s2});
      end
    end
  endtask

`ifdef INT_EXEC_ZICOND_EN
  task automatic test_zicond();
    logic [31:0] zb   [4] = '{32'h0, 32'h5, 32'h5, 32'h0};
    int          zop  [4] = '{10, 11, 10, 11};
    logic [31:0] zexp [4] = '{32'h0, 32'h0, 32'h1234, 32'h1234};
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(zop[i], 32'h1234, zb[i], 5'd1);
      cyc();
      checks++;
      if ({o_valid_s1, o_illegal_s1, o_res_s1} !== {2'b10, zexp[i]}) begin
        errors++; $display("FAIL zicond[%0d]: got v/ill=%b res=%h expected 10 %h",
          i, {o_valid_s1, o_illegal_s1}, o_res_s1, zexp[i]);
      end
    end
    idle(3);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_backpressure();
    test_flush();
    test_illegal();
`ifdef INT_EXEC_ZICOND_EN
    test_zicond();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
